det_matrix_loader: RTL and testbench
====================================

# det_matrix_loader

Operand front-end for the 4x4 determinant unit. Accepts a 4x4 signed 8-bit matrix as a byte stream with a valid/ready handshake and drives the sixteen element ports plus a one-cycle start pulse into the determinant unit. It then waits for the unit's done, captures the 16-bit result and presents it on a valid/ready result port. A watchdog flags a determinant unit that never answers.

## Interface
- TIMEOUT, 64: cycles spent in WAIT without det_done before an error result is produced; legal range 16..255.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  signed matrix element, row-major order (a,b,c,d,e,…,p).
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts an element this cycle.
- flush  input  1  synchronous; in LOAD, discards the partially loaded matrix.
- a … p  output  8 each  signed element registers; connect to the determinant unit's element ports.
- det_start  output  1  one-cycle start pulse to the determinant unit.
- det_done  input  1  done pulse from the determinant unit.
- det_result  input  16  determinant from the determinant unit; valid while det_done=1.
- res_data  output  16  captured determinant (two's complement), or 0 on error.
- res_err  output  1  1 = watchdog expired; qualifies res_data.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- busy  output  1  high in START and WAIT.

## Operation
- States: LOAD, START, WAIT, HOLD. Reset state is LOAD.
- LOAD:
  - in_ready=1.
  - Each edge with in_valid=1 writes in_data to element[cnt] and increments the 4-bit cnt (0=a … 15=p).
  - The accept with cnt=15 moves to START and resets cnt to 0.
  - flush=1 forces cnt to 0 and blocks the accept in the same cycle. Element registers keep their old values.
- START:
  - det_start=1 (decoded from state, exactly one cycle).
  - The watchdog counter clears.
  - Next edge moves to WAIT.
- WAIT:
  - On an edge with det_done=1: res_data<=det_result, res_err<=0, res_valid<=1, go to HOLD.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 without done: res_data<=0, res_err<=1, res_valid<=1, go to HOLD.
- HOLD:
  - res_valid=1; res_data and res_err are stable.
  - An edge with res_ready=1 clears res_valid and returns to LOAD.
- Element ports a…p change only in LOAD. They stay stable from the first START cycle through HOLD, because the determinant unit reads elements up to its final cycle.
- det_done in any state other than WAIT is ignored.
- The result is passed through unchanged. The loader does no width extension and no overflow check.
- flush is ignored outside LOAD. There is no mid-computation abort other than rst_n.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=LOAD, cnt=0, watchdog=0.
  - a…p=0, res_data=0, res_err=0, res_valid=0, det_start=0.
  - in_ready=1 once reset is released.
- Reset asserted mid-WAIT abandons the computation. A det_done arriving afterwards is ignored (state is LOAD).
- Element rate: one element per cycle; 16 elements take a minimum of 16 cycles.
- Start: the edge that accepts p (edge N) is followed by det_start=1 for cycle N→N+1. WAIT begins at edge N+1.
- Capture: res_valid rises on the edge after the cycle in which det_done=1 is sampled. The result is visible from that edge.
- Timeout: with det_done held 0, res_valid rises TIMEOUT cycles after WAIT is entered.
- Throughput: in_ready is 0 from START until the edge that completes the result handshake. in_ready=1 in the cycle after res_valid falls, so there is no combinational path from res_ready to in_ready.
- A res_ready that is high before res_valid rises completes the handshake on the first edge where both are high.

## Test plan
- Identity matrix (1,0,0,0 / 0,1,0,0 / 0,0,1,0 / 0,0,0,1), in_valid held high, det unit attached:
  - det_start pulses exactly once, one cycle after the 16th accept.
  - res_data=0x0001, res_err=0.
- diag(2,2,2,2) -> res_data=0x0010. diag(-1,1,1,1) -> res_data=0xFFFF.
- Singular matrix (row 2 equals row 1, e.g. rows 1,2,3,4 / 1,2,3,4 / 0,1,0,0 / 0,0,1,0) -> res_data=0x0000, res_err=0.
- Backpressure:
  - Hold res_ready=0 for 5 cycles after res_valid rises: res_valid, res_data and a…p stay stable, and in_ready=0 throughout.
  - Raise res_ready: res_valid falls on that edge, and in_ready=1 the next cycle.
- Watchdog: tie det_done=0 with TIMEOUT=16 -> res_valid rises 16 cycles after WAIT entry with res_err=1 and res_data=0. A late det_done pulse in HOLD changes nothing.
- Abort cases:
  - Load 7 elements, then pulse flush (and separately, rst_n): the next 16 elements form a fresh matrix, giving the identity result 0x0001 with no stray det_start.
  - Assert rst_n mid-WAIT: all outputs are 0 immediately.

Source files
------------

// File: rtl/det_matrix_loader.sv
// Byte-stream operand loader for the 4x4 determinant unit.
// Streams sixteen signed elements in, starts the unit, and returns its result.
module det_matrix_loader #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [7:0]  c,
  output logic [7:0]  d,
  output logic [7:0]  e,
  output logic [7:0]  f,
  output logic [7:0]  g,
  output logic [7:0]  h,
  output logic [7:0]  i,
  output logic [7:0]  j,
  output logic [7:0]  k,
  output logic [7:0]  l,
  output logic [7:0]  m,
  output logic [7:0]  n,
  output logic [7:0]  o,
  output logic [7:0]  p,
  output logic        det_start,
  input  logic        det_done,
  input  logic [15:0] det_result,
  output logic [15:0] res_data,
  output logic        res_err,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    HOLD
  } state_t;

  localparam logic [7:0] WD_MAX = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] wd;
  logic [7:0] elem [16];

  assign in_ready  = (state == LOAD);
  assign det_start = (state == START);
  assign busy      = (state == START) || (state == WAIT);

  assign a = elem[0];
  assign b = elem[1];
  assign c = elem[2];
  assign d = elem[3];
  assign e = elem[4];
  assign f = elem[5];
  assign g = elem[6];
  assign h = elem[7];
  assign i = elem[8];
  assign j = elem[9];
  assign k = elem[10];
  assign l = elem[11];
  assign m = elem[12];
  assign n = elem[13];
  assign o = elem[14];
  assign p = elem[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      cnt       <= '0;
      wd        <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
      for (int x = 0; x < 16; x++) begin
        elem[x] <= '0;
      end
    end else begin
      unique case (state)
        LOAD: begin
          if (flush) begin
            cnt <= '0;
          end else if (in_valid) begin
            elem[cnt] <= in_data;
            cnt       <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state <= START;
            end
          end
        end
        START: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // a done arriving on the last watchdog cycle still wins
          if (det_done) begin
            res_data  <= det_result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else if (wd == WD_MAX) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= LOAD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_det_matrix_loader.sv
// Bench for det_matrix_loader: vector table, random matrices and corner
// sequences against a behavioural determinant unit and reference model.
module tb_det_matrix_loader;

  localparam int TO = 16;

  typedef logic [15:0][7:0] mat_t;
  typedef struct {
    string       nm;
    mat_t        mx;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [7:0]  a, b, c, d, e, f, g, h;
  logic [7:0]  i, j, k, l, m, n, o, p;
  logic        det_start;
  logic        det_done;
  logic [15:0] det_result;
  logic [15:0] res_data;
  logic        res_err;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  logic        mdl_done = 1'b0;
  logic        man_done;
  bit          det_en;
  int          det_lat;
  int          pend = 0;
  int          starts = 0;
  int          tests = 0;
  int          fails = 0;
  mat_t        pm;

  assign det_done = mdl_done | man_done;
  assign pm = {p, o, n, m, l, k, j, i, h, g, f, e, d, c, b, a};

  always #5 clk = ~clk;

  det_matrix_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .i(i), .j(j), .k(k), .l(l), .m(m), .n(n), .o(o), .p(p),
    .det_start(det_start), .det_done(det_done),
    .det_result(det_result),
    .res_data(res_data), .res_err(res_err),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  function automatic longint det4(mat_t mx);
    longint v[4][4];
    longint s;
    longint t[3][3];
    int cc;
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++)
        v[r][q] = longint'($signed(mx[r*4+q]));
    s = 0;
    for (int c0 = 0; c0 < 4; c0++) begin
      for (int r = 1; r < 4; r++) begin
        cc = 0;
        for (int q = 0; q < 4; q++) begin
          if (q != c0) begin
            t[r-1][cc] = v[r][q];
            cc++;
          end
        end
      end
      s += ((c0 % 2) ? -1 : 1) * v[0][c0] *
           (t[0][0] * (t[1][1]*t[2][2] - t[1][2]*t[2][1])
          - t[0][1] * (t[1][0]*t[2][2] - t[1][2]*t[2][0])
          + t[0][2] * (t[1][0]*t[2][1] - t[1][1]*t[2][0]));
    end
    return s;
  endfunction

  // behavioural determinant unit driven off the element ports
  always @(negedge clk) begin
    if (det_start) starts++;
    if (mdl_done) mdl_done = 1'b0;
    if (det_start && det_en) begin
      pend = det_lat;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        det_result = 16'(det4(pm));
        mdl_done = 1'b1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic mat_t diag(logic [7:0] x0, logic [7:0] x1,
                                logic [7:0] x2, logic [7:0] x3);
    mat_t r = '0;
    r[0] = x0; r[5] = x1; r[10] = x2; r[15] = x3;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(mat_t mx, bit gaps);
    for (int x = 0; x < 16; x++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_data  = mx[x];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_res(string nm);
    int cy = 0;
    while (!res_valid && cy < 300) begin
      tick();
      cy++;
    end
    chk({nm, "_resv"}, res_valid, 1);
  endtask

  task automatic run_one(string nm, mat_t mx, logic [15:0] exp,
                         bit gaps, bit early);
    int s0 = starts;
    res_ready = early;
    load(mx, gaps);
    chk({nm, "_start"}, {det_start, busy, in_ready}, 3'b110);
    tick();
    chk({nm, "_start_end"}, det_start, 0);
    wait_res(nm);
    chk({nm, "_data"}, res_data, exp);
    chk({nm, "_err"}, res_err, 0);
    chk({nm, "_nstart"}, starts - s0, 1);
    res_ready = 1'b1;
    tick();
    chk({nm, "_release"}, {res_valid, in_ready}, 2'b01);
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  vec_t tbl[4];
  mat_t ident;
  mat_t rm;
  mat_t sing;
  logic [15:0] sd;
  logic [7:0]  sa;
  bit          bad;
  int          cy;

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0;
    res_ready = 1'b0; man_done = 1'b0; det_result = '0;
    det_en = 1'b1; det_lat = 3;
    ident = diag(1, 1, 1, 1);
    sing = '0;
    for (int x = 0; x < 4; x++) begin
      sing[x]   = 8'(x + 1);
      sing[4+x] = 8'(x + 1);
    end
    sing[9] = 1; sing[14] = 1;
    tbl[0] = '{"ident", ident, 16'h0001};
    tbl[1] = '{"diag2", diag(2, 2, 2, 2), 16'h0010};
    tbl[2] = '{"diagm1", diag(8'hFF, 1, 1, 1), 16'hFFFF};
    tbl[3] = '{"singular", sing, 16'h0000};

    #3;
    chk("rst_async", {res_valid, det_start, busy, res_err}, 0);
    #10;
    rst_n = 1'b1;
    tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_elem", pm, 0);
    chk("rst_data", res_data, 0);

    for (int x = 0; x < 4; x++)
      run_one(tbl[x].nm, tbl[x].mx, tbl[x].exp, 0, 0);

    for (int r = 0; r < 20; r++) begin
      for (int x = 0; x < 16; x++) rm[x] = 8'($urandom_range(0, 255));
      det_lat = $urandom_range(1, 10);
      run_one($sformatf("rand%0d", r), rm, 16'(det4(rm)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    det_lat = 3;

    // result held under backpressure
    load(ident, 0);
    wait_res("bp");
    sd = res_data;
    sa = a;
    bad = 0;
    for (int x = 0; x < 5; x++) begin
      tick();
      if (!res_valid || res_data !== sd || a !== sa || pm !== ident ||
          in_ready) bad = 1;
    end
    chk("bp_stable", bad, 0);
    res_ready = 1'b1;
    #1;
    chk("bp_no_comb", in_ready, 0);
    tick();
    chk("bp_release", {res_valid, in_ready}, 2'b01);
    res_ready = 1'b0;

    // watchdog
    det_en = 1'b0;
    load(ident, 0);
    tick();
    cy = 0;
    while (!res_valid && cy < 100) begin
      tick();
      cy++;
    end
    chk("wd_cycles", cy, TO);
    chk("wd_result", {res_err, res_data}, 17'h10000);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    chk("wd_late_done", {res_valid, res_err, res_data}, 18'h30000);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    det_en = 1'b1;

    // flush mid-load
    in_valid = 1'b1;
    for (int x = 0; x < 7; x++) begin
      in_data = 8'(x + 9);
      tick();
    end
    flush = 1'b1;
    in_data = 8'h55;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    run_one("flush", ident, 16'h0001, 0, 0);

    // reset mid-load
    in_valid = 1'b1;
    for (int x = 0; x < 7; x++) begin
      in_data = 8'(x + 3);
      tick();
    end
    in_valid = 1'b0;
    do_reset();
    run_one("rstload", ident, 16'h0001, 0, 0);

    // reset mid-WAIT, late done must be ignored
    det_lat = 30;
    load(ident, 0);
    repeat (5) tick();
    chk("mw_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mw_zero", {res_valid, res_err, res_data, det_start, busy}, 0);
    chk("mw_elem", pm, 0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int x = 0; x < 40; x++) begin
      tick();
      if (res_valid || busy || !in_ready) bad = 1;
    end
    chk("mw_ignored", bad, 0);
    det_lat = 2;
    run_one("after_mw", tbl[1].mx, 16'h0010, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
